spart_bus_ctrl: RTL and testbench
=================================

Name: spart_bus_ctrl

Overview:
- Bus-side controller for the UART datapath. Holds the programmable baud divisor and generates the one-cycle baud enable pulse used by the receiver and transmitter.
- Maps a 4-register processor bus onto the datapath:
  - receive holding register
  - transmit launch
  - status
  - divisor low and high bytes
- Sits between the processor bus and the receiver/transmitter pair. Owns the RDA and TBR handshakes.

Parameters:
- DIV_WIDTH, 16, width of the divisor register and the baud counter. Fixed by the bus map at 16; other values are unsupported.
- DEFAULT_DIVISOR, 16'd325, divisor loaded at reset (50 MHz, 9600 baud, 16x).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- iocs  in  1  bus chip select; a transfer occurs in each cycle where iocs=1.
- iorw  in  1  1 = read, 0 = write.
- ioaddr  in  2  register select: 00 data, 01 status, 10 DB_LO, 11 DB_HI.
- bus_wdata  in  8  write data.
- bus_rdata  out  8  read data; combinational from the registers.
- baud_en  out  1  one-cycle pulse at each divisor expiry.
- rx_valid  in  1  receiver pulse: rx_byte is complete.
- rx_byte  in  8  byte from the receiver.
- tx_start  out  1  one-cycle launch pulse to the transmitter.
- tx_byte  out  8  byte to transmit; held stable until tx_done.
- tx_done  in  1  transmitter pulse: frame finished.
- rda  out  1  receive data available.
- tbr  out  1  transmit buffer ready.

Behaviour:
- Reset values (reset=0):
  - divisor = DEFAULT_DIVISOR; baud counter = DEFAULT_DIVISOR.
  - baud_en=0, tx_start=0, tx_byte=0, rx holding register = 0.
  - rda=0, tbr=1, overrun=0.
  - Reset asserted mid-frame aborts everything. No tx_start is issued after release until a new write.
- Baud generator:
  - Down-counter decrements every cycle.
  - When count==0: baud_en=1 for that cycle and the counter reloads with the divisor. Period = divisor+1 cycles.
  - Divisor values 0 and 1 both produce baud_en every cycle.
- Divisor writes:
  - A DB_LO write updates divisor[7:0] only; the counter is not touched.
  - A DB_HI write updates divisor[15:8] and reloads the counter with the new full divisor on the next edge. Software programs DB_LO then DB_HI.
- Reads:
  - addr 00 → rx holding register.
  - addr 01 → {5'b0, overrun, tbr, rda}.
  - addr 10/11 → divisor low/high byte.
  - When iocs=0, bus_rdata = 8'h00.
- Receive path, evaluated per cycle:
  - rx_valid with rda=0: capture rx_byte; rda=1 next cycle.
  - Data read (iocs, iorw, addr 00) and no rx_valid in the same cycle: rda=0 next cycle.
  - Data read and rx_valid in the same cycle: the read returns the old byte, the new byte is captured, rda stays 1, and this is not an overrun.
  - rx_valid with rda=1 and no data read: see the Optional Feature.
- Transmit path:
  - A data write (iocs, ~iorw, addr 00) with tbr=1 latches bus_wdata into tx_byte. Next cycle: tx_start=1 (one cycle) and tbr=0.
  - A data write with tbr=0 is ignored: tx_byte is unchanged and no pulse is issued.
  - tx_done sets tbr=1 on the next edge.
  - A write in the same cycle as tx_done is ignored, because tbr is still 0 in that cycle.
  - tx_done while tbr=1 has no effect.
- Other writes: writes to the status register have no effect.

Optional Feature:
- Macro: SPART_OVERRUN_DETECT_EN.
- Defined:
  - rx_valid while rda=1, with no data read in the same cycle, discards the new byte. The holding register keeps the old byte and the sticky overrun flag is set.
  - A status read clears overrun on the next edge.
  - If a new overrun occurs in the same cycle as the status read, overrun stays 1.
- Undefined:
  - The new byte overwrites the holding register and rda stays 1.
  - Status bit 2 always reads 0.

Test Plan:
1. Reset, then idle for 1000 cycles → baud_en pulses every 326 cycles; status=8'h02; bus_rdata=8'h00 with iocs=0.
2. Write DB_LO=8'h04, then DB_HI=8'h00 → counter reloads, and baud_en then pulses every 5 cycles. Reading addr 10/11 returns 8'h04 and 8'h00.
3. Write data 8'hA5 → tx_start for exactly 1 cycle, tx_byte=8'hA5, tbr=0.
   - A second write of 8'h3C before tx_done is ignored and tx_byte stays 8'hA5.
   - tx_done → tbr=1 the next cycle.
4. rx_valid with rx_byte=8'h5A → rda=1 and a data read returns 8'h5A, with rda=0 the next cycle. Then rx_valid(8'h11) coincident with a read → old value returned, 8'h11 captured, rda=1.
5. rx_valid(8'h22), then rx_valid(8'h33) without a read:
   - With SPART_OVERRUN_DETECT_EN: data reads 8'h22 and status=8'h07; after the status read, status=8'h03.
   - Without the macro: data reads 8'h33 and status=8'h03.
6. Assert reset mid-transmit (tbr=0) with rda=1 → all outputs at reset values, divisor=325, and no tx_start after release.

Source files
------------

// File: rtl/spart_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : spart_bus_ctrl
//  Purpose  : Bus-side controller for the SPART UART datapath. Holds the
//             programmable baud divisor, generates the one-cycle baud enable
//             and maps a 4-register processor bus onto the receiver and
//             transmitter (RDA / TBR handshakes).
//  Ports    : clk, reset (async, active-low)
//             iocs/iorw/ioaddr/bus_wdata/bus_rdata - processor bus
//               ioaddr 00 data, 01 status {5'b0,overrun,tbr,rda},
//               10 divisor low byte, 11 divisor high byte
//             baud_en                 - one-cycle pulse at divisor expiry
//             rx_valid/rx_byte        - receiver byte hand-off
//             tx_start/tx_byte/tx_done - transmitter launch and completion
//             rda/tbr                 - receive available / transmit ready
//  Option   : SPART_OVERRUN_DETECT_EN - when defined, a byte arriving while
//             rda=1 (and no data read) is dropped and a sticky overrun flag
//             is set; otherwise the new byte overwrites the holding register.
//  Revision : 1.0 - initial release
// ============================================================================
module spart_bus_ctrl #(
  parameter int                   DIV_WIDTH       = 16,
  parameter logic [DIV_WIDTH-1:0] DEFAULT_DIVISOR = 16'd325
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       iocs,
  input  logic       iorw,
  input  logic [1:0] ioaddr,
  input  logic [7:0] bus_wdata,
  output logic [7:0] bus_rdata,
  output logic       baud_en,
  input  logic       rx_valid,
  input  logic [7:0] rx_byte,
  output logic       tx_start,
  output logic [7:0] tx_byte,
  input  logic       tx_done,
  output logic       rda,
  output logic       tbr
);

  localparam logic [1:0] c_ADDR_DATA   = 2'b00;
  localparam logic [1:0] c_ADDR_STATUS = 2'b01;
  localparam logic [1:0] c_ADDR_DB_LO  = 2'b10;
  localparam logic [1:0] c_ADDR_DB_HI  = 2'b11;

  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]           rx_hold_q, rx_hold_d;
  logic [7:0]           tx_byte_q, tx_byte_d;
  logic                 rda_q, rda_d;
  logic                 tbr_q, tbr_d;
  logic                 tx_start_q, tx_start_d;
  logic                 ovr_q, ovr_d;

  logic                 w_data_rd;
  logic                 w_status_rd;
  logic                 w_data_wr;
  logic                 w_lo_wr;
  logic                 w_hi_wr;
  logic [DIV_WIDTH-1:0] w_new_div;

  assign w_data_rd   = iocs &  iorw & (ioaddr == c_ADDR_DATA);
  assign w_status_rd = iocs &  iorw & (ioaddr == c_ADDR_STATUS);
  assign w_data_wr   = iocs & ~iorw & (ioaddr == c_ADDR_DATA);
  assign w_lo_wr     = iocs & ~iorw & (ioaddr == c_ADDR_DB_LO);
  assign w_hi_wr     = iocs & ~iorw & (ioaddr == c_ADDR_DB_HI);
  assign w_new_div   = {bus_wdata, div_q[7:0]};

  // Divisors 0 and 1 must both pulse every cycle, so both reload the
  // counter with 0; larger values reload with the divisor itself, giving a
  // period of divisor+1.
  function automatic logic [DIV_WIDTH-1:0] f_reload(input logic [DIV_WIDTH-1:0] d);
    return (d[DIV_WIDTH-1:1] != '0) ? d : '0;
  endfunction

  // --------------------------------------------------------------------------
  // Divisor register and baud down-counter
  // --------------------------------------------------------------------------
  always_comb begin
    div_d = div_q;
    cnt_d = cnt_q;
    if (w_lo_wr) begin
      div_d = {div_q[15:8], bus_wdata};
    end
    // A high-byte write commits the full divisor and restarts the period.
    if (w_hi_wr) begin
      div_d = w_new_div;
      cnt_d = f_reload(w_new_div);
    end else if (cnt_q == '0) begin
      cnt_d = f_reload(div_q);
    end else begin
      cnt_d = cnt_q - DIV_WIDTH'(1);
    end
  end

  // --------------------------------------------------------------------------
  // Receive holding register, RDA and overrun
  // --------------------------------------------------------------------------
  always_comb begin
    rx_hold_d = rx_hold_q;
    rda_d     = rda_q;
    ovr_d     = ovr_q;
`ifdef SPART_OVERRUN_DETECT_EN
    if (rx_valid) begin
      // A read in the same cycle frees the register, so capture is legal.
      if (!rda_q || w_data_rd) begin
        rx_hold_d = rx_byte;
        rda_d     = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (w_data_rd) begin
      rda_d = 1'b0;
    end
    // A fresh overrun wins over the clear-on-status-read.
    if (w_status_rd && !(rx_valid && rda_q && !w_data_rd)) begin
      ovr_d = 1'b0;
    end
`else
    if (rx_valid) begin
      rx_hold_d = rx_byte;
      rda_d     = 1'b1;
    end else if (w_data_rd) begin
      rda_d = 1'b0;
    end
    ovr_d = 1'b0;
`endif
  end

  // --------------------------------------------------------------------------
  // Transmit launch and TBR
  // --------------------------------------------------------------------------
  always_comb begin
    tx_byte_d  = tx_byte_q;
    tbr_d      = tbr_q;
    tx_start_d = 1'b0;
    if (tx_done && !tbr_q) begin
      tbr_d = 1'b1;
    end else if (w_data_wr && tbr_q) begin
      tx_byte_d  = bus_wdata;
      tbr_d      = 1'b0;
      tx_start_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q      <= DEFAULT_DIVISOR;
      cnt_q      <= DEFAULT_DIVISOR;
      rx_hold_q  <= 8'h00;
      tx_byte_q  <= 8'h00;
      rda_q      <= 1'b0;
      tbr_q      <= 1'b1;
      tx_start_q <= 1'b0;
      ovr_q      <= 1'b0;
    end else begin
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      rx_hold_q  <= rx_hold_d;
      tx_byte_q  <= tx_byte_d;
      rda_q      <= rda_d;
      tbr_q      <= tbr_d;
      tx_start_q <= tx_start_d;
      ovr_q      <= ovr_d;
    end
  end

  // --------------------------------------------------------------------------
  // Read mux and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    bus_rdata = 8'h00;
    if (iocs) begin
      case (ioaddr)
        c_ADDR_DATA:   bus_rdata = rx_hold_q;
        c_ADDR_STATUS: bus_rdata = {5'b00000, ovr_q, tbr_q, rda_q};
        c_ADDR_DB_LO:  bus_rdata = div_q[7:0];
        default:       bus_rdata = div_q[15:8];
      endcase
    end
  end

  assign baud_en  = (cnt_q == '0);
  assign tx_start = tx_start_q;
  assign tx_byte  = tx_byte_q;
  assign rda      = rda_q;
  assign tbr      = tbr_q;

endmodule
`default_nettype wire

// File: tb/tb_spart_bus_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spart_bus_ctrl
//  Purpose  : Self-checking bench for spart_bus_ctrl. Directed scenarios plus
//             randomized bus/receiver/transmitter traffic, every cycle
//             compared against a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_spart_bus_ctrl;

  logic       clk       = 1'b0;
  logic       reset     = 1'b1;
  logic       iocs      = 1'b0;
  logic       iorw      = 1'b0;
  logic [1:0] ioaddr    = 2'b00;
  logic [7:0] bus_wdata = 8'h00;
  logic       rx_valid  = 1'b0;
  logic [7:0] rx_byte   = 8'h00;
  logic       tx_done   = 1'b0;
  logic [7:0] bus_rdata;
  logic       baud_en;
  logic       tx_start;
  logic [7:0] tx_byte;
  logic       rda;
  logic       tbr;

  spart_bus_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .iocs      (iocs),
    .iorw      (iorw),
    .ioaddr    (ioaddr),
    .bus_wdata (bus_wdata),
    .bus_rdata (bus_rdata),
    .baud_en   (baud_en),
    .rx_valid  (rx_valid),
    .rx_byte   (rx_byte),
    .tx_start  (tx_start),
    .tx_byte   (tx_byte),
    .tx_done   (tx_done),
    .rda       (rda),
    .tbr       (tbr)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int pulses   = 0;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         cyc;      // cycles since reset release
  int         m_next;   // cycle index of the next expected baud pulse
  logic [15:0] m_div;
  logic [7:0] m_rx, m_txb;
  bit         m_rda, m_tbr, m_ovr, m_txs;

  function automatic int period(input logic [15:0] d);
    return (d < 16'd2) ? 1 : int'(d) + 1;
  endfunction

  function automatic logic [7:0] exp_rdata();
    if (!iocs) return 8'h00;
    case (ioaddr)
      2'd0:    return m_rx;
      2'd1:    return {5'b0, m_ovr, m_tbr, m_rda};
      2'd2:    return m_div[7:0];
      default: return m_div[15:8];
    endcase
  endfunction

  task automatic model_reset();
    cyc = 0; m_div = 16'd325; m_next = 325;
    m_rx = 8'h00; m_txb = 8'h00;
    m_rda = 0; m_tbr = 1; m_ovr = 0; m_txs = 0;
  endtask

  task automatic model_edge();
    bit rd_data, rd_stat, wr_data, new_ovr;
    logic [15:0] old_div;
    rd_data = iocs &&  iorw && ioaddr == 2'd0;
    rd_stat = iocs &&  iorw && ioaddr == 2'd1;
    wr_data = iocs && !iorw && ioaddr == 2'd0;
    new_ovr = 0;
    if (rx_valid) begin
      if (!m_rda || rd_data) begin
        m_rx = rx_byte; m_rda = 1;
      end else begin
`ifdef SPART_OVERRUN_DETECT_EN
        new_ovr = 1;
`else
        m_rx = rx_byte;
`endif
      end
    end else if (rd_data) begin
      m_rda = 0;
    end
    if (new_ovr) m_ovr = 1;
    else if (rd_stat) m_ovr = 0;
    m_txs = 0;
    if (tx_done && !m_tbr) m_tbr = 1;
    else if (wr_data && m_tbr) begin
      m_txb = bus_wdata; m_tbr = 0; m_txs = 1;
    end
    old_div = m_div;
    if (iocs && !iorw && ioaddr == 2'd2) m_div[7:0] = bus_wdata;
    if (iocs && !iorw && ioaddr == 2'd3) begin
      m_div[15:8] = bus_wdata;
      m_next = cyc + period(m_div);
    end else if (cyc == m_next) begin
      m_next = cyc + period(old_div);
    end
    cyc++;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic set_in(input logic cs, input logic rw, input logic [1:0] a, input logic [7:0] wd,
                        input logic rxv, input logic [7:0] rxb, input logic txd);
    iocs = cs; iorw = rw; ioaddr = a; bus_wdata = wd;
    rx_valid = rxv; rx_byte = rxb; tx_done = txd;
  endtask

  // Called at a negedge with inputs applied: check, clock, update model.
  task automatic step();
    #1;
    chk("baud_en", baud_en, (cyc == m_next));
    chk("bus_rdata", bus_rdata, exp_rdata());
    chk("rda", rda, m_rda);
    chk("tbr", tbr, m_tbr);
    chk("tx_start", tx_start, m_txs);
    chk("tx_byte", tx_byte, m_txb);
    if (baud_en) pulses++;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    set_in(0, 0, 2'd0, 8'h00, 0, 8'h00, 0);
    repeat (n) step();
  endtask

  task automatic bus_wr(input logic [1:0] a, input logic [7:0] d);
    set_in(1, 0, a, d, 0, 8'h00, 0);
    step();
  endtask

  task automatic do_reset();
    set_in(0, 0, 2'd0, 8'h00, 0, 8'h00, 0);
    #3 reset = 1'b0;
    #1;
    chk("rst_tx_start", tx_start, 1'b0);
    chk("rst_tbr", tbr, 1'b1);
    chk("rst_rda", rda, 1'b0);
    chk("rst_baud_en", baud_en, 1'b0);
    chk("rst_tx_byte", tx_byte, 8'h00);
    chk("rst_rdata_nocs", bus_rdata, 8'h00);
    set_in(1, 1, 2'd1, 8'h00, 0, 8'h00, 0); #1 chk("rst_status", bus_rdata, 8'h02);
    set_in(1, 1, 2'd0, 8'h00, 0, 8'h00, 0); #1 chk("rst_rxhold", bus_rdata, 8'h00);
    set_in(1, 1, 2'd2, 8'h00, 0, 8'h00, 0); #1 chk("rst_db_lo", bus_rdata, 8'h45);
    set_in(1, 1, 2'd3, 8'h00, 0, 8'h00, 0); #1 chk("rst_db_hi", bus_rdata, 8'h01);
    set_in(0, 0, 2'd0, 8'h00, 0, 8'h00, 0);
    repeat (2) @(negedge clk);
    model_reset();
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] a;
    logic [7:0] d;
    model_reset();
    do_reset();

    // 1. idle after reset: pulses at cycles 325, 651, 977
    pulses = 0;
    idle(1000);
    chk("baud_pulses_default", pulses, 3);
    set_in(1, 1, 2'd1, 8'h00, 0, 8'h00, 0); #1 chk("status_idle", bus_rdata, 8'h02); step();
    set_in(0, 1, 2'd1, 8'h00, 0, 8'h00, 0); #1 chk("rdata_nocs", bus_rdata, 8'h00); step();

    // 2. divisor 4 -> period 5
    bus_wr(2'd2, 8'h04);
    bus_wr(2'd3, 8'h00);
    pulses = 0;
    idle(20);
    chk("baud_pulses_div4", pulses, 4);
    set_in(1, 1, 2'd2, 8'h00, 0, 8'h00, 0); #1 chk("db_lo_rd", bus_rdata, 8'h04); step();
    set_in(1, 1, 2'd3, 8'h00, 0, 8'h00, 0); #1 chk("db_hi_rd", bus_rdata, 8'h00); step();

    // 3. transmit launch, ignored second write, tx_done
    bus_wr(2'd0, 8'hA5);
    set_in(1, 1, 2'd1, 8'h00, 0, 8'h00, 0); #1;
    chk("tx_start_pulse", tx_start, 1'b1);
    chk("tx_byte_a5", tx_byte, 8'hA5);
    chk("status_tx_busy", bus_rdata, 8'h00);
    step();
    set_in(1, 0, 2'd0, 8'h3C, 0, 8'h00, 0); #1 chk("tx_start_one_cycle", tx_start, 1'b0); step();
    idle(3);
    chk("tx_byte_held", tx_byte, 8'hA5);
    chk("no_second_start", tx_start, 1'b0);
    set_in(0, 0, 2'd0, 8'h00, 0, 8'h00, 1); step();
    idle(1);
    chk("tbr_after_done", tbr, 1'b1);

    // 4. receive, read, coincident receive+read
    set_in(0, 0, 2'd0, 8'h00, 1, 8'h5A, 0); step();
    set_in(1, 1, 2'd0, 8'h00, 0, 8'h00, 0); #1;
    chk("rda_set", rda, 1'b1);
    chk("rx_5a", bus_rdata, 8'h5A);
    step();
    set_in(1, 1, 2'd0, 8'h00, 1, 8'h11, 0); #1;
    chk("rda_cleared", rda, 1'b0);
    chk("rd_old_byte", bus_rdata, 8'h5A);
    step();
    set_in(1, 1, 2'd0, 8'h00, 0, 8'h00, 0); #1;
    chk("rda_coincident", rda, 1'b1);
    chk("rx_11", bus_rdata, 8'h11);
    step();

    // 5. overrun scenario
    set_in(0, 0, 2'd0, 8'h00, 1, 8'h22, 0); step();
    idle(1);
    set_in(0, 0, 2'd0, 8'h00, 1, 8'h33, 0); step();
`ifdef SPART_OVERRUN_DETECT_EN
    set_in(1, 1, 2'd1, 8'h00, 0, 8'h00, 0); #1 chk("status_ovr", bus_rdata, 8'h07); step();
    set_in(1, 1, 2'd1, 8'h00, 0, 8'h00, 0); #1 chk("status_ovr_clr", bus_rdata, 8'h03); step();
    set_in(1, 1, 2'd0, 8'h00, 0, 8'h00, 0); #1 chk("rx_kept_22", bus_rdata, 8'h22); step();
`else
    set_in(1, 1, 2'd1, 8'h00, 0, 8'h00, 0); #1 chk("status_no_ovr", bus_rdata, 8'h03); step();
    set_in(1, 1, 2'd0, 8'h00, 0, 8'h00, 0); #1 chk("rx_overwrite_33", bus_rdata, 8'h33); step();
`endif

    // 6. reset mid-transmit with rda=1
    bus_wr(2'd0, 8'hC3);
    set_in(0, 0, 2'd0, 8'h00, 1, 8'h77, 0); step();
    #1 chk("pre_rst_tbr", tbr, 1'b0);
    chk("pre_rst_rda", rda, 1'b1);
    do_reset();
    idle(30);
    set_in(1, 1, 2'd2, 8'h00, 0, 8'h00, 0); #1 chk("post_rst_db_lo", bus_rdata, 8'h45); step();
    set_in(1, 1, 2'd3, 8'h00, 0, 8'h00, 0); #1 chk("post_rst_db_hi", bus_rdata, 8'h01); step();

    // Randomized traffic against the model, with one reset in the middle
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      a = 2'($urandom_range(0, 3));
      if (a == 2'd3)      d = ($urandom_range(0, 9) == 0) ? 8'h01 : 8'h00;
      else if (a == 2'd2) d = 8'($urandom_range(0, 12));
      else                d = 8'($urandom_range(0, 255));
      set_in(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, d,
             ($urandom_range(0, 4) == 0), 8'($urandom_range(0, 255)),
             ($urandom_range(0, 7) == 0));
      step();
    end
    idle(5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
